// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
// The bus request struct lets the controller build and gate a request as one value.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [3:0]  BE_WORD           = 4'hF;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [3:0]  byteenable;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '{read: 1'b0, write: 1'b0,
                                      address: 32'h0000_0000, byteenable: 4'h0};

    // Load/store request for the EXEC phase; a load takes priority over a store.
    function automatic bus_req_t ls_request(input logic        is_load,
                                            input logic        is_store,
                                            input logic [31:0] address,
                                            input logic [3:0]  byteenable);
        bus_req_t req;
        req = BUS_IDLE;
        if (is_load) begin
            req.read = 1'b1;
        end else begin
            req.write = is_store;
        end
        if (is_load || is_store) begin
            req.address    = address;
            req.byteenable = byteenable;
        end else begin
            req.address    = 32'h0000_0000;
            req.byteenable = 4'h0;
        end
        return req;
    endfunction

    // Instruction fetch request for a given PC.
    function automatic bus_req_t fetch_request(input logic [31:0] pc);
        bus_req_t req;
        req = '{read: 1'b1, write: 1'b0, address: pc, byteenable: BE_WORD};
        return req;
    endfunction

endpackage

// File: rtl/mips_cycle_controller.sv
// FETCH/EXEC sequencer for the bus-based MIPS CPU: owns the memory port,
// drives PC stall/state, detects halt and counts retired instructions.
module mips_cycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [31:0]      ls_address,
    input  logic [3:0]       ls_byteenable,
    input  logic [31:0]      ls_writedata,
    input  logic             mem_waitrequest,
    input  logic [31:0]      mem_readdata,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_byteenable,
    output logic [31:0]      mem_writedata,
    output logic [31:0]      instr_reg,
    output logic [31:0]      load_data,
    output logic             stall,
    output logic             state,
    output logic             commit,
    output logic             active,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t      state_r;
    ctrl_state_t      state_nxt_s;
    bus_req_t         req_s;
    logic             stall_s;
    logic             commit_s;
    logic             at_halt_s;
    logic             exec_done_s;
    logic             fetch_done_s;
    logic [31:0]      instr_reg_r;
    logic [CNT_W-1:0] instr_count_r;
    logic             active_r;

    assign at_halt_s    = (pc == HALT_ADDR);
    assign exec_done_s  = !((is_load || is_store) && mem_waitrequest);
    assign fetch_done_s = (state_r == FETCH) && !at_halt_s && !mem_waitrequest;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FETCH: begin
                if (at_halt_s) begin
                    state_nxt_s = HALTED;
                end else if (!mem_waitrequest) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            EXEC: begin
                if (exec_done_s) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            HALTED:  state_nxt_s = HALTED;
            default: state_nxt_s = FETCH;
        endcase
    end

    // Bus request and PC handshake per state; stalled unless EXEC completes.
    always_comb begin
        req_s    = BUS_IDLE;
        stall_s  = 1'b1;
        commit_s = 1'b0;
        case (state_r)
            FETCH: begin
                if (at_halt_s) begin
                    req_s = BUS_IDLE;
                end else begin
                    req_s = fetch_request(pc);
                end
            end
            EXEC: begin
                req_s = ls_request(is_load, is_store, ls_address, ls_byteenable);
                if (exec_done_s) begin
                    stall_s  = 1'b0;
                    commit_s = 1'b1;
                end else begin
                    stall_s  = 1'b1;
                    commit_s = 1'b0;
                end
            end
            HALTED:  req_s = BUS_IDLE;
            default: req_s = BUS_IDLE;
        endcase
    end

    // Fetched instruction, retire counter and run flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_reg_r   <= 32'h0000_0000;
            instr_count_r <= CNT_ZERO;
            active_r      <= 1'b1;
        end else begin
            if (fetch_done_s) begin
                instr_reg_r <= mem_readdata;
            end
            if (commit_s) begin
                instr_count_r <= instr_count_r + CNT_ONE;
            end
            if (state_nxt_s == HALTED) begin
                active_r <= 1'b0;
            end
        end
    end

    // Reset must kill any in-flight request immediately, not at the next edge.
    assign mem_read       = req_s.read  && !rst;
    assign mem_write      = req_s.write && !rst;
    assign mem_address    = req_s.address;
    assign mem_byteenable = req_s.byteenable;
    assign mem_writedata  = ls_writedata;
    assign commit         = commit_s && !rst;
    assign stall          = stall_s;
    assign state          = (state_r == EXEC);
    assign load_data      = mem_readdata;
    assign instr_reg      = instr_reg_r;
    assign instr_count    = instr_count_r;
    assign active         = active_r;

endmodule

// File: tb/tb_mips_cycle_controller.sv
// Directed bench for mips_cycle_controller: fetch, waits, load/store, halt, reset.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_mips_cycle_controller;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        is_load;
    logic        is_store;
    logic [31:0] ls_address;
    logic [3:0]  ls_byteenable;
    logic [31:0] ls_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] instr_reg;
    logic [31:0] load_data;
    logic        stall;
    logic        state;
    logic        commit;
    logic        active;
    logic [31:0] instr_count;

    logic [31:0] w2_mem_address;
    logic        w2_mem_read;
    logic        w2_mem_write;
    logic [3:0]  w2_mem_byteenable;
    logic [31:0] w2_mem_writedata;
    logic [31:0] w2_instr_reg;
    logic [31:0] w2_load_data;
    logic        w2_stall;
    logic        w2_state;
    logic        w2_commit;
    logic        w2_active;
    logic [1:0]  w2_instr_count;

    int checks;
    int failures;

    mips_cycle_controller u_dut (
        .clk(clk), .rst(rst), .pc(pc), .is_load(is_load), .is_store(is_store),
        .ls_address(ls_address), .ls_byteenable(ls_byteenable),
        .ls_writedata(ls_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .instr_reg(instr_reg), .load_data(load_data), .stall(stall),
        .state(state), .commit(commit), .active(active),
        .instr_count(instr_count)
    );

    mips_cycle_controller #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .pc(pc), .is_load(is_load), .is_store(is_store),
        .ls_address(ls_address), .ls_byteenable(ls_byteenable),
        .ls_writedata(ls_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_address(w2_mem_address),
        .mem_read(w2_mem_read), .mem_write(w2_mem_write),
        .mem_byteenable(w2_mem_byteenable), .mem_writedata(w2_mem_writedata),
        .instr_reg(w2_instr_reg), .load_data(w2_load_data), .stall(w2_stall),
        .state(w2_state), .commit(w2_commit), .active(w2_active),
        .instr_count(w2_instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; pc = 32'hBFC0_0000; is_load = 1'b0; is_store = 1'b0;
        ls_address = 32'h0; ls_byteenable = 4'h0; ls_writedata = 32'h0;
        mem_waitrequest = 1'b0; mem_readdata = 32'h2402_0005;
        #1;
        chk("rst_read", {31'b0, mem_read}, 32'd0);
        chk("rst_write", {31'b0, mem_write}, 32'd0);
        tick();
        chk("rst_state", {31'b0, state}, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_active", {31'b0, active}, 32'd1);
        chk("rst_ir", instr_reg, 32'h0);

        // Zero-wait instruction: FETCH then EXEC.
        rst = 1'b0; #1;
        chk("f1_read", {31'b0, mem_read}, 32'd1);
        chk("f1_addr", mem_address, 32'hBFC0_0000);
        chk("f1_be", {28'b0, mem_byteenable}, 32'hF);
        chk("f1_stall", {31'b0, stall}, 32'd1);
        chk("f1_state", {31'b0, state}, 32'd0);
        chk("f1_commit", {31'b0, commit}, 32'd0);
        tick();
        chk("e1_state", {31'b0, state}, 32'd1);
        chk("e1_commit", {31'b0, commit}, 32'd1);
        chk("e1_stall", {31'b0, stall}, 32'd0);
        chk("e1_read", {31'b0, mem_read}, 32'd0);
        chk("e1_ir", instr_reg, 32'h2402_0005);
        tick();
        chk("cnt1", instr_count, 32'd1);
        chk("cnt1_state", {31'b0, state}, 32'd0);

        // Fetch held off by three waitrequest cycles.
        pc = 32'h0000_0100; mem_waitrequest = 1'b1; mem_readdata = 32'hFFFF_FFFF; #1;
        for (int i = 0; i < 3; i++) begin
            chk("fw_read", {31'b0, mem_read}, 32'd1);
            chk("fw_addr", mem_address, 32'h0000_0100);
            chk("fw_stall", {31'b0, stall}, 32'd1);
            chk("fw_state", {31'b0, state}, 32'd0);
            tick();
        end
        mem_waitrequest = 1'b0; mem_readdata = 32'h8C22_1004; #1;
        chk("fw4_read", {31'b0, mem_read}, 32'd1);
        chk("fw4_state", {31'b0, state}, 32'd0);
        tick();
        chk("fw_exec", {31'b0, state}, 32'd1);
        chk("fw_ir", instr_reg, 32'h8C22_1004);

        // Load with two wait cycles; instr_reg must not follow readdata.
        is_load = 1'b1; ls_address = 32'h0000_1004; ls_byteenable = 4'h3;
        mem_waitrequest = 1'b1; mem_readdata = 32'h0BAD_0BAD; #1;
        for (int i = 0; i < 2; i++) begin
            chk("ld_read", {31'b0, mem_read}, 32'd1);
            chk("ld_addr", mem_address, 32'h0000_1004);
            chk("ld_be", {28'b0, mem_byteenable}, 32'h3);
            chk("ld_stall", {31'b0, stall}, 32'd1);
            chk("ld_commit", {31'b0, commit}, 32'd0);
            chk("ld_ir", instr_reg, 32'h8C22_1004);
            tick();
        end
        mem_waitrequest = 1'b0; mem_readdata = 32'hDEAD_BEEF; #1;
        chk("ld3_read", {31'b0, mem_read}, 32'd1);
        chk("ld3_commit", {31'b0, commit}, 32'd1);
        chk("ld3_stall", {31'b0, stall}, 32'd0);
        chk("ld3_data", load_data, 32'hDEAD_BEEF);
        tick();
        chk("cnt2", instr_count, 32'd2);
        chk("cnt2_state", {31'b0, state}, 32'd0);

        // Zero-wait store.
        is_load = 1'b0; pc = 32'h0000_0104; mem_readdata = 32'hAC22_1008; #1;
        tick();
        is_store = 1'b1; ls_address = 32'h0000_1008; ls_byteenable = 4'hF;
        ls_writedata = 32'h1234_5678; #1;
        chk("st_write", {31'b0, mem_write}, 32'd1);
        chk("st_read", {31'b0, mem_read}, 32'd0);
        chk("st_commit", {31'b0, commit}, 32'd1);
        chk("st_addr", mem_address, 32'h0000_1008);
        chk("st_be", {28'b0, mem_byteenable}, 32'hF);
        chk("st_wdata", mem_writedata, 32'h1234_5678);
        tick();
        chk("cnt3", instr_count, 32'd3);

        // Load and store together: load wins.
        pc = 32'h0000_0108; is_store = 1'b0; ls_writedata = 32'hCAFE_F00D; #1;
        chk("fetch_wdata", mem_writedata, 32'hCAFE_F00D);
        tick();
        is_load = 1'b1; is_store = 1'b1; ls_address = 32'h0000_100C; ls_byteenable = 4'hC; #1;
        chk("lsb_read", {31'b0, mem_read}, 32'd1);
        chk("lsb_write", {31'b0, mem_write}, 32'd0);
        chk("lsb_be", {28'b0, mem_byteenable}, 32'hC);
        chk("lsb_commit", {31'b0, commit}, 32'd1);
        tick();
        chk("cnt4", instr_count, 32'd4);
        chk("cnt_wrap", {30'b0, w2_instr_count}, 32'd0);

        // Halt at PC 0 and stay halted even if PC/decode inputs change.
        is_load = 1'b0; is_store = 1'b0; pc = 32'h0000_0000; #1;
        chk("h_read", {31'b0, mem_read}, 32'd0);
        chk("h_stall", {31'b0, stall}, 32'd1);
        chk("h_active0", {31'b0, active}, 32'd1);
        tick();
        chk("h_active", {31'b0, active}, 32'd0);
        pc = 32'h0000_0200; is_load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hl_read", {31'b0, mem_read}, 32'd0);
            chk("hl_write", {31'b0, mem_write}, 32'd0);
            chk("hl_commit", {31'b0, commit}, 32'd0);
            chk("hl_stall", {31'b0, stall}, 32'd1);
            chk("hl_state", {31'b0, state}, 32'd0);
            chk("hl_active", {31'b0, active}, 32'd0);
            chk("hl_count", instr_count, 32'd4);
            tick();
        end

        // Reset in the middle of a waited load.
        rst = 1'b1; is_load = 1'b0; #1;
        tick();
        rst = 1'b0; pc = 32'h0000_0200; mem_waitrequest = 1'b0; mem_readdata = 32'h8C23_2000; #1;
        tick();
        is_load = 1'b1; ls_address = 32'h0000_2000; ls_byteenable = 4'hF; mem_waitrequest = 1'b1; #1;
        chk("r_read", {31'b0, mem_read}, 32'd1);
        tick();
        chk("r_wait_state", {31'b0, state}, 32'd1);
        rst = 1'b1; #1;
        chk("r_read_rst", {31'b0, mem_read}, 32'd0);
        chk("r_write_rst", {31'b0, mem_write}, 32'd0);
        chk("r_commit_rst", {31'b0, commit}, 32'd0);
        tick();
        chk("r_state", {31'b0, state}, 32'd0);
        chk("r_count", instr_count, 32'd0);
        chk("r_active", {31'b0, active}, 32'd1);
        chk("r_ir", instr_reg, 32'h0);
        rst = 1'b0; #1;
        chk("r_fetch_read", {31'b0, mem_read}, 32'd1);
        chk("r_fetch_addr", mem_address, 32'h0000_0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cycle_controller.md
Name: mips_cycle_controller

Overview:
Multi-cycle sequencer for the bus-based MIPS CPU. It alternates FETCH and EXEC phases and drives the STALL and state inputs of the PC/branch unit. It owns the single Avalon-style memory port, arbitrating instruction fetch against load/store access and honouring waitrequest. It also detects the halt condition, drives the CPU-level active flag and counts retired instructions.

Parameters:
HALT_ADDR, 32'h0000_0000, PC value that terminates execution when reached at FETCH
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
pc  in  32  current PC from the PC/branch unit
is_load  in  1  current instruction (instr_reg) is a load
is_store  in  1  current instruction is a store
ls_address  in  32  effective load/store address from ALU
ls_byteenable  in  4  byte lanes for the load/store
ls_writedata  in  32  store data, already lane-aligned
mem_waitrequest  in  1  memory not ready; hold request
mem_readdata  in  32  memory read data
mem_address  out  32  memory address
mem_read  out  1  read request
mem_write  out  1  write request
mem_byteenable  out  4  byte lanes
mem_writedata  out  32  write data
instr_reg  out  32  latched instruction for decode
load_data  out  32  load result, valid when commit=1 and is_load
stall  out  1  to PC/branch unit STALL; 1 = PC holds this edge
state  out  1  to PC/branch unit state; 0 = FETCH, 1 = EXEC
commit  out  1  one-cycle strobe: register write-back / retire
active  out  1  1 while running, 0 once halted
instr_count  out  CNT_W  retired instructions

Behaviour:
- Internal states: FETCH, EXEC, HALTED. state output is 1 only in EXEC.
- Reset (sync, rst=1 at an edge) gives: FETCH, instr_reg=0, instr_count=0, active=1. Reset overrides any in-flight bus request; request outputs are 0 while rst=1.
- All memory outputs are combinational from state and inputs. mem_writedata = ls_writedata at all times.
- FETCH, pc==HALT_ADDR:
  - no request issued; next state HALTED.
- FETCH, pc!=HALT_ADDR:
  - mem_read=1, mem_address=pc, mem_byteenable=4'hF, stall=1.
  - If mem_waitrequest=1, remain in FETCH with outputs held stable.
  - If mem_waitrequest=0, instr_reg<=mem_readdata and move to EXEC.
- EXEC, is_load=1:
  - mem_read=1, mem_address=ls_address, mem_byteenable=ls_byteenable.
- EXEC, is_store=1 and is_load=0:
  - mem_write=1, same address and byteenable rules as a load.
- EXEC, is_load and is_store both 1: load wins, store suppressed.
- EXEC completion:
  - Waiting: while a request is outstanding with mem_waitrequest=1, stall=1, commit=0, remain in EXEC.
  - Complete: no access, or access with mem_waitrequest=0. Then stall=0 (the PC/branch unit advances on this edge), commit=1, load_data=mem_readdata, instr_count increments (wraps at 2^CNT_W), next state FETCH.
- Latency: zero-wait instruction takes exactly 2 cycles (FETCH, EXEC). Each waitrequest cycle adds 1.
- HALTED: sticky until rst. active=0, stall=1, no requests, commit=0, instr_count frozen.
- instr_reg is stable throughout EXEC. It changes only on fetch completion.
- No request is deasserted or changed while mem_waitrequest=1.

Decomposition:
- Shared package cpu_ctrl_pkg: state enum (FETCH/EXEC/HALTED), HALT_ADDR default, byteenable constant BE_WORD=4'hF.
- No sub-module required. The bus request mux may be a local always_comb.

Test Plan:
- Reset, pc=32'hBFC0_0000, readdata=32'h2402_0005, no wait -> cycle1 mem_read=1 addr BFC00000 stall=1 state=0; cycle2 state=1 commit=1 stall=0; instr_reg=24020005; instr_count=1.
- Fetch with waitrequest=1 for 3 cycles -> mem_read and address held 3 cycles, stall=1 throughout; EXEC entered on 4th cycle.
- Load in EXEC: ls_address=32'h0000_1004, be=4'h3, wait 2 cycles, readdata=32'hDEAD_BEEF -> mem_read held 3 cycles; commit and load_data=DEADBEEF on the third; stall=0 only then.
- Store: ls_writedata=32'h1234_5678, be=4'hF, no wait -> mem_write=1 one cycle, mem_read=0, commit=1 same cycle; is_load=is_store=1 -> only mem_read asserted.
- Jump to 0: after a commit, pc=0 at FETCH -> no mem_read, next cycle active=0; 5 further cycles with no requests, instr_count unchanged.
- rst=1 during a waited load -> next cycle FETCH, mem_write/mem_read=0 while rst high, instr_count=0, active=1.
